// File: rtl/ibex_bcp_fault_unit_pkg.sv
// Shared types for the bound-check fault unit: fault causes, FSM states and
// the cause-priority helper.
package ibex_bcp_fault_unit_pkg;

    typedef enum logic [1:0] {
        BCP_FAULT_NONE  = 2'd0,
        BCP_FAULT_LOAD  = 2'd1,
        BCP_FAULT_STORE = 2'd2,
        BCP_FAULT_ARITH = 2'd3
    } bcp_fault_cause_e;

    typedef enum logic [1:0] {
        BCP_IDLE     = 2'd0,
        BCP_PEND_NEW = 2'd1,
        BCP_WAIT_CLR = 2'd2,
        BCP_PEND_OVR = 2'd3
    } bcp_fault_state_e;

    // Load outranks store, store outranks arith.
    function automatic bcp_fault_cause_e bcp_cause(input logic ld, input logic st, input logic ar);
        if (ld) begin
            return BCP_FAULT_LOAD;
        end else if (st) begin
            return BCP_FAULT_STORE;
        end else if (ar) begin
            return BCP_FAULT_ARITH;
        end else begin
            return BCP_FAULT_NONE;
        end
    endfunction

endpackage

// File: rtl/ibex_bcp_fault_unit_if.sv
// Bundle of bound-checker inputs, controller handshake and CSR readout for
// the bound-check fault unit.
interface ibex_bcp_fault_unit_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CntWidth = 16
);
    logic                instr_valid_i;
    logic                bcp_load_addr_err_i;
    logic                bcp_store_addr_err_i;
    logic                bcp_arith_addr_err_i;
    logic [XLEN-1:0]     fault_addr_i;
    logic [XLEN-1:0]     fault_pc_i;
    logic                bcp_stall_o;
    logic                bcp_exc_req_o;
    logic [1:0]          bcp_exc_cause_o;
    logic                bcp_exc_ack_i;
    logic                csr_fault_valid_o;
    logic [1:0]          csr_fault_cause_o;
    logic [XLEN-1:0]     csr_fault_addr_o;
    logic [XLEN-1:0]     csr_fault_pc_o;
    logic                csr_overrun_o;
    logic [CntWidth-1:0] csr_fault_cnt_o;
    logic                csr_fault_clr_i;
    logic                csr_cnt_clr_i;

    modport slave (
        input  instr_valid_i, bcp_load_addr_err_i, bcp_store_addr_err_i, bcp_arith_addr_err_i,
        input  fault_addr_i, fault_pc_i, bcp_exc_ack_i, csr_fault_clr_i, csr_cnt_clr_i,
        output bcp_stall_o, bcp_exc_req_o, bcp_exc_cause_o, csr_fault_valid_o,
        output csr_fault_cause_o, csr_fault_addr_o, csr_fault_pc_o, csr_overrun_o, csr_fault_cnt_o
    );

    modport master (
        output instr_valid_i, bcp_load_addr_err_i, bcp_store_addr_err_i, bcp_arith_addr_err_i,
        output fault_addr_i, fault_pc_i, bcp_exc_ack_i, csr_fault_clr_i, csr_cnt_clr_i,
        input  bcp_stall_o, bcp_exc_req_o, bcp_exc_cause_o, csr_fault_valid_o,
        input  csr_fault_cause_o, csr_fault_addr_o, csr_fault_pc_o, csr_overrun_o, csr_fault_cnt_o
    );
endinterface

// File: rtl/ibex_bcp_fault_unit_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment leaves 1 so the
// event that arrived with the clear is not lost.
module ibex_bcp_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);
    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] r_count;

    // Count register with clear priority and saturation at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= inc_i ? One : '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + One;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/ibex_bcp_fault_unit.sv
// Qualifies bound-check violations, stalls EX, raises a req/ack exception to
// the controller and keeps a sticky first-fault record plus a violation count.
module ibex_bcp_fault_unit
    import ibex_bcp_fault_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CntWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_bcp_fault_unit_if.slave bus
);
    bcp_fault_state_e r_state, w_state_nxt;
    bcp_fault_cause_e r_exc_cause, w_exc_cause_nxt;
    bcp_fault_cause_e r_fault_cause, w_fault_cause_nxt;
    bcp_fault_cause_e w_cause;
    logic             r_exc_req, r_fault_valid, r_overrun;
    logic             w_fault_valid_nxt, w_overrun_nxt;
    logic [XLEN-1:0]  r_fault_addr, r_fault_pc, w_fault_addr_nxt, w_fault_pc_nxt;
    logic             w_err_q, w_cnt_inc, w_stall;
    logic [CntWidth-1:0] w_cnt;

    assign w_err_q = bus.instr_valid_i &
                     (bus.bcp_load_addr_err_i | bus.bcp_store_addr_err_i | bus.bcp_arith_addr_err_i);
    assign w_cause = bcp_cause(bus.bcp_load_addr_err_i, bus.bcp_store_addr_err_i,
                               bus.bcp_arith_addr_err_i);

    // Next-state, record update, count increment and stall.
    always_comb begin
        w_state_nxt       = r_state;
        w_exc_cause_nxt   = r_exc_cause;
        w_fault_valid_nxt = r_fault_valid;
        w_fault_cause_nxt = r_fault_cause;
        w_fault_addr_nxt  = r_fault_addr;
        w_fault_pc_nxt    = r_fault_pc;
        w_overrun_nxt     = r_overrun;
        w_cnt_inc         = 1'b0;
        w_stall           = w_err_q;
        case (r_state)
            BCP_IDLE, BCP_WAIT_CLR: begin
                if (r_state == BCP_WAIT_CLR && bus.csr_fault_clr_i && !w_err_q) begin
                    w_state_nxt       = BCP_IDLE;
                    w_fault_valid_nxt = 1'b0;
                    w_fault_cause_nxt = BCP_FAULT_NONE;
                    w_fault_addr_nxt  = '0;
                    w_fault_pc_nxt    = '0;
                    w_overrun_nxt     = 1'b0;
                end else if (w_err_q && (r_state == BCP_IDLE || bus.csr_fault_clr_i)) begin
                    // Fresh record: either nothing held, or the clear wins over the old one.
                    w_state_nxt       = BCP_PEND_NEW;
                    w_exc_cause_nxt   = w_cause;
                    w_fault_valid_nxt = 1'b1;
                    w_fault_cause_nxt = w_cause;
                    w_fault_addr_nxt  = bus.fault_addr_i;
                    w_fault_pc_nxt    = bus.fault_pc_i;
                    w_overrun_nxt     = 1'b0;
                    w_cnt_inc         = 1'b1;
                end else if (w_err_q) begin
                    w_state_nxt     = BCP_PEND_OVR;
                    w_exc_cause_nxt = w_cause;
                    w_overrun_nxt   = 1'b1;
                    w_cnt_inc       = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            BCP_PEND_NEW, BCP_PEND_OVR: begin
                w_stall = 1'b1;
                if (bus.bcp_exc_ack_i) begin
                    w_state_nxt = BCP_WAIT_CLR;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = BCP_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= BCP_IDLE;
            r_exc_req     <= 1'b0;
            r_exc_cause   <= BCP_FAULT_NONE;
            r_fault_valid <= 1'b0;
            r_fault_cause <= BCP_FAULT_NONE;
            r_fault_addr  <= '0;
            r_fault_pc    <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_exc_req     <= (w_state_nxt == BCP_PEND_NEW) || (w_state_nxt == BCP_PEND_OVR);
            r_exc_cause   <= w_exc_cause_nxt;
            r_fault_valid <= w_fault_valid_nxt;
            r_fault_cause <= w_fault_cause_nxt;
            r_fault_addr  <= w_fault_addr_nxt;
            r_fault_pc    <= w_fault_pc_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    ibex_bcp_sat_counter #(
        .Width (CntWidth)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_cnt_inc),
        .clr_i   (bus.csr_cnt_clr_i),
        .count_o (w_cnt)
    );

    assign bus.bcp_stall_o       = w_stall;
    assign bus.bcp_exc_req_o     = r_exc_req;
    assign bus.bcp_exc_cause_o   = r_exc_cause;
    assign bus.csr_fault_valid_o = r_fault_valid;
    assign bus.csr_fault_cause_o = r_fault_cause;
    assign bus.csr_fault_addr_o  = r_fault_addr;
    assign bus.csr_fault_pc_o    = r_fault_pc;
    assign bus.csr_overrun_o     = r_overrun;
    assign bus.csr_fault_cnt_o   = w_cnt;

endmodule

// File: tb/tb_ibex_bcp_fault_unit.sv
// Vector-table bench for the bound-check fault unit, with a small scoreboard
// for registered outputs and hand sequences for reset and saturation.
module tb_ibex_bcp_fault_unit;

    typedef struct {
        string       name;
        logic        vld, ld, st, ar;
        logic [31:0] addr, pc;
        logic        ack, fclr, cclr;
        logic        e_stall, e_req;
        logic [1:0]  e_cause;
        logic        e_valid;
        logic [1:0]  e_rcause;
        logic [31:0] e_raddr, e_rpc;
        logic        e_ovr;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic        req;
        logic [1:0]  cause;
        logic        valid;
        logic [1:0]  rcause;
        logic [31:0] raddr, rpc;
        logic        ovr;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[17];
    exp_t sb[$];

    always #5 clk = ~clk;

    ibex_bcp_fault_unit_if #(.XLEN(32), .CntWidth(16)) bif ();
    ibex_bcp_fault_unit_if #(.XLEN(32), .CntWidth(4))  bif2 ();

    ibex_bcp_fault_unit #(.XLEN(32), .CntWidth(16)) u_dut (
        .clk_i (clk), .rst_ni (rst_n), .bus (bif)
    );

    ibex_bcp_fault_unit #(.XLEN(32), .CntWidth(4)) u_dut_sat (
        .clk_i (clk), .rst_ni (rst_n), .bus (bif2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bif.instr_valid_i        = v.vld;
        bif.bcp_load_addr_err_i  = v.ld;
        bif.bcp_store_addr_err_i = v.st;
        bif.bcp_arith_addr_err_i = v.ar;
        bif.fault_addr_i         = v.addr;
        bif.fault_pc_i           = v.pc;
        bif.bcp_exc_ack_i        = v.ack;
        bif.csr_fault_clr_i      = v.fclr;
        bif.csr_cnt_clr_i        = v.cclr;
    endtask

    task automatic idle_sat();
        bif2.instr_valid_i        = 1'b0;
        bif2.bcp_load_addr_err_i  = 1'b0;
        bif2.bcp_store_addr_err_i = 1'b0;
        bif2.bcp_arith_addr_err_i = 1'b0;
        bif2.fault_addr_i         = 32'h0;
        bif2.fault_pc_i           = 32'h0;
        bif2.bcp_exc_ack_i        = 1'b0;
        bif2.csr_fault_clr_i      = 1'b0;
        bif2.csr_cnt_clr_i        = 1'b0;
    endtask

    initial begin
        exp_t e;
        //                name           vld  ld   st   ar   addr          pc          ack  fclr cclr  stall req  cause valid rcause raddr         rpc         ovr  cnt
        vecs[0]  = '{"idle",         1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,32'h0,        32'h0,      1'b0,16'd0};
        vecs[1]  = '{"store_err",    1'b1,1'b0,1'b1,1'b0,32'h0000_1004,32'h80,     1'b0,1'b0,1'b0, 1'b1,1'b1,2'd2,1'b1,2'd2,32'h0000_1004,32'h80,     1'b0,16'd1};
        vecs[2]  = '{"hold1",        1'b1,1'b0,1'b1,1'b0,32'h0000_1004,32'h80,     1'b0,1'b0,1'b0, 1'b1,1'b1,2'd2,1'b1,2'd2,32'h0000_1004,32'h80,     1'b0,16'd1};
        vecs[3]  = '{"hold_clr_ign", 1'b1,1'b0,1'b1,1'b0,32'h0000_1004,32'h80,     1'b0,1'b1,1'b0, 1'b1,1'b1,2'd2,1'b1,2'd2,32'h0000_1004,32'h80,     1'b0,16'd1};
        vecs[4]  = '{"hold3",        1'b1,1'b0,1'b1,1'b0,32'h0000_1004,32'h80,     1'b0,1'b0,1'b0, 1'b1,1'b1,2'd2,1'b1,2'd2,32'h0000_1004,32'h80,     1'b0,16'd1};
        vecs[5]  = '{"ack1",         1'b1,1'b0,1'b1,1'b0,32'h0000_1004,32'h80,     1'b1,1'b0,1'b0, 1'b1,1'b0,2'd2,1'b1,2'd2,32'h0000_1004,32'h80,     1'b0,16'd1};
        vecs[6]  = '{"wait_quiet",   1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b0,1'b0,1'b0, 1'b0,1'b0,2'd2,1'b1,2'd2,32'h0000_1004,32'h80,     1'b0,16'd1};
        vecs[7]  = '{"ovr_err",      1'b1,1'b0,1'b0,1'b1,32'h0000_2000,32'h84,     1'b0,1'b0,1'b0, 1'b1,1'b1,2'd3,1'b1,2'd2,32'h0000_1004,32'h80,     1'b1,16'd2};
        vecs[8]  = '{"ovr_clr_ign",  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b0,1'b1,1'b0, 1'b1,1'b1,2'd3,1'b1,2'd2,32'h0000_1004,32'h80,     1'b1,16'd2};
        vecs[9]  = '{"ovr_ack",      1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b1,1'b0,1'b0, 1'b1,1'b0,2'd3,1'b1,2'd2,32'h0000_1004,32'h80,     1'b1,16'd2};
        vecs[10] = '{"clr_and_err",  1'b1,1'b1,1'b0,1'b1,32'h0000_3000,32'h90,     1'b0,1'b1,1'b0, 1'b1,1'b1,2'd1,1'b1,2'd1,32'h0000_3000,32'h90,     1'b0,16'd3};
        vecs[11] = '{"ack2",         1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b1,1'b0,1'b0, 1'b1,1'b0,2'd1,1'b1,2'd1,32'h0000_3000,32'h90,     1'b0,16'd3};
        vecs[12] = '{"clr_only",     1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b0,1'b1,1'b0, 1'b0,1'b0,2'd1,1'b0,2'd0,32'h0,        32'h0,      1'b0,16'd3};
        vecs[13] = '{"unqualified",  1'b0,1'b0,1'b1,1'b0,32'h0000_5000,32'h99,     1'b0,1'b0,1'b0, 1'b0,1'b0,2'd1,1'b0,2'd0,32'h0,        32'h0,      1'b0,16'd3};
        vecs[14] = '{"cnt_clr",      1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b0,1'b0,1'b1, 1'b0,1'b0,2'd1,1'b0,2'd0,32'h0,        32'h0,      1'b0,16'd0};
        vecs[15] = '{"ld_ar_cclr",   1'b1,1'b1,1'b0,1'b1,32'h0000_0040,32'hA0,     1'b0,1'b0,1'b1, 1'b1,1'b1,2'd1,1'b1,2'd1,32'h0000_0040,32'hA0,     1'b0,16'd1};
        vecs[16] = '{"pend_hold",    1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,      1'b0,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,2'd1,32'h0000_0040,32'hA0,     1'b0,16'd1};

        apply(vecs[0]);
        idle_sat();
        #1;
        chk("reset.req",   {63'd0, bif.bcp_exc_req_o},     64'd0);
        chk("reset.cause", {62'd0, bif.bcp_exc_cause_o},   64'd0);
        chk("reset.valid", {63'd0, bif.csr_fault_valid_o}, 64'd0);
        chk("reset.cnt",   {48'd0, bif.csr_fault_cnt_o},   64'd0);
        chk("reset.stall", {63'd0, bif.bcp_stall_o},       64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk({vecs[i].name, ".stall"}, {63'd0, bif.bcp_stall_o}, {63'd0, vecs[i].e_stall});
            sb.push_back('{vecs[i].name, vecs[i].e_req, vecs[i].e_cause, vecs[i].e_valid,
                           vecs[i].e_rcause, vecs[i].e_raddr, vecs[i].e_rpc, vecs[i].e_ovr,
                           vecs[i].e_cnt});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.name, ".req"},    {63'd0, bif.bcp_exc_req_o},     {63'd0, e.req});
            chk({e.name, ".cause"},  {62'd0, bif.bcp_exc_cause_o},   {62'd0, e.cause});
            chk({e.name, ".valid"},  {63'd0, bif.csr_fault_valid_o}, {63'd0, e.valid});
            chk({e.name, ".rcause"}, {62'd0, bif.csr_fault_cause_o}, {62'd0, e.rcause});
            chk({e.name, ".raddr"},  {32'd0, bif.csr_fault_addr_o},  {32'd0, e.raddr});
            chk({e.name, ".rpc"},    {32'd0, bif.csr_fault_pc_o},    {32'd0, e.rpc});
            chk({e.name, ".ovr"},    {63'd0, bif.csr_overrun_o},     {63'd0, e.ovr});
            chk({e.name, ".cnt"},    {48'd0, bif.csr_fault_cnt_o},   {48'd0, e.cnt});
        end

        // Asynchronous reset while a request is pending takes effect immediately.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst.req",   {63'd0, bif.bcp_exc_req_o},     64'd0);
        chk("async_rst.stall", {63'd0, bif.bcp_stall_o},       64'd0);
        chk("async_rst.valid", {63'd0, bif.csr_fault_valid_o}, 64'd0);
        chk("async_rst.addr",  {32'd0, bif.csr_fault_addr_o},  64'd0);
        chk("async_rst.cnt",   {48'd0, bif.csr_fault_cnt_o},   64'd0);
        apply(vecs[0]);
        @(negedge clk);
        rst_n = 1'b1;

        // Store error and ack held: one increment every two cycles until saturation.
        @(negedge clk);
        bif2.instr_valid_i        = 1'b1;
        bif2.bcp_store_addr_err_i = 1'b1;
        bif2.bcp_exc_ack_i        = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("sat.cnt_mid",  {60'd0, bif2.csr_fault_cnt_o}, 64'd10);
        repeat (20) @(posedge clk);
        #1;
        chk("sat.cnt_full", {60'd0, bif2.csr_fault_cnt_o}, 64'hF);
        chk("sat.overrun",  {63'd0, bif2.csr_overrun_o},   64'd1);
        chk("sat.rcause",   {62'd0, bif2.csr_fault_cause_o}, 64'd2);
        idle_sat();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibex_bcp_fault_unit.md
Name: ibex_bcp_fault_unit

Overview:
Sits directly downstream of the bound-checking stage in EX. It qualifies the load/store/arith bound-violation flags, stalls EX and raises a registered exception request to the controller with a req/ack handshake. It captures a sticky first-fault record (cause, address, PC) for CSR readout and keeps a saturating violation counter.

Parameters:
XLEN, 32, datapath width for address and PC records
CntWidth, 16, width of saturating violation counter

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
instr_valid_i  in  1  EX instruction valid; qualifies all error inputs
bcp_load_addr_err_i  in  1  load bound violation from bound checker
bcp_store_addr_err_i  in  1  store bound violation
bcp_arith_addr_err_i  in  1  INCP/DECP/CVTIP/SETAG violation
fault_addr_i  in  XLEN  EX adder result (faulting address)
fault_pc_i  in  XLEN  PC of EX instruction
bcp_stall_o  out  1  stall EX (combinational)
bcp_exc_req_o  out  1  exception request to controller
bcp_exc_cause_o  out  2  cause of pending request
bcp_exc_ack_i  in  1  controller accepted exception
csr_fault_valid_o  out  1  first-fault record valid
csr_fault_cause_o  out  2  recorded cause
csr_fault_addr_o  out  XLEN  recorded address
csr_fault_pc_o  out  XLEN  recorded PC
csr_overrun_o  out  1  fault occurred while record held
csr_fault_cnt_o  out  CntWidth  violation count
csr_fault_clr_i  in  1  clear record and overrun (one-cycle pulse)
csr_cnt_clr_i  in  1  clear counter (one-cycle pulse)

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0; counter 0; records 0.
- Qualified error err_q = instr_valid_i & (load|store|arith). Cause priority load(1) > store(2) > arith(3); cause 0 = none.
- bcp_stall_o = err_q in IDLE/WAIT_CLR, plus 1 throughout PEND_NEW/PEND_OVR.
- FSM states: IDLE, PEND_NEW, WAIT_CLR, PEND_OVR.
- IDLE: on err_q, capture cause/addr/pc, set fault_valid, count+1, go PEND_NEW.
- PEND_NEW: bcp_exc_req_o=1, cause stable; err_q ignored (same held instruction, no recount); on ack go WAIT_CLR.
- WAIT_CLR: req=0. err_q without clr: record untouched, set overrun, count+1, latch cause into exc cause only, go PEND_OVR. clr without err_q: clear valid/overrun/record, go IDLE. clr with err_q: clear wins, then capture new record as in IDLE, go PEND_NEW.
- PEND_OVR: as PEND_NEW; on ack go WAIT_CLR.
- csr_fault_clr_i ignored in PEND_* states.
- Latency: error in cycle N -> req high in N+1, held until ack sampled; req drops the cycle after ack.
- Counter saturates at all-ones. csr_cnt_clr_i with simultaneous increment yields 1.
- Outputs registered except bcp_stall_o.

Decomposition:
- ibex_pkg: bcp_fault_cause_e (BCP_FAULT_NONE=0, BCP_FAULT_LOAD=1, BCP_FAULT_STORE=2, BCP_FAULT_ARITH=3), bcp_fault_state_e.
- Sub-module ibex_bcp_sat_counter (parameter Width; inc, clr, count).

Test Plan:
- Store error, addr 0x0000_1004, pc 0x80 -> stall same cycle; req next cycle with cause 2; record {2,0x1004,0x80}; count 1.
- Load+arith same cycle -> cause 1 recorded; count 1.
- Error held 5 cycles in PEND_NEW, ack on cycle 4 -> count stays 1; WAIT_CLR; req low the cycle after ack.
- Second error in WAIT_CLR, addr 0x2000 -> overrun 1; record keeps first addr; req cause of second; count 2.
- clr and err together in WAIT_CLR -> record replaced, overrun 0, PEND_NEW.
- Counter at 0xFFFF plus error -> stays 0xFFFF. rst_ni low during PEND_NEW -> req 0, state IDLE immediately.
